hilo_muldiv_seq: RTL and testbench

- Multi-cycle sequencer for the HI/LO register pair.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO commands from the EX stage.
- Runs a radix-2 iterative multiply or a restoring divide, then drives HI/LO data and a 2-bit write-enable to the HI/LO register block.
- Raises busy so the pipeline stalls any later HI/LO access until writeback completes.

---
 rtl/hilo_pkg.sv | 58 +++++
 rtl/hilo_iter_core.sv | 66 ++++++
 rtl/hilo_muldiv_seq.sv | 269 ++++++++++++++++++++++++++
 tb/tb_hilo_muldiv_seq.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// Shared types for the HI/LO multiply/divide sequencer.
// HILO_MULDIV_ACC_EN widens the op code to 4 bits and adds MADD/MSUB(U).
package hilo_pkg;

  localparam int XLEN_FIX = 32;
  localparam int ITER     = 32;
  localparam int CNT_W    = $clog2(ITER);

`ifdef HILO_MULDIV_ACC_EN
  localparam int OP_W = 4;
`else
  localparam int OP_W = 3;
`endif

  // MADDU/MSUBU reuse the MADD/MSUB encodings with op[3] set
  typedef enum logic [OP_W-1:0] {
    OP_MULT  = OP_W'(0),
    OP_MULTU = OP_W'(1),
    OP_DIV   = OP_W'(2),
    OP_DIVU  = OP_W'(3),
    OP_MTHI  = OP_W'(4),
    OP_MTLO  = OP_W'(5),
    OP_MADD  = OP_W'(6),
    OP_MSUB  = OP_W'(7)
`ifdef HILO_MULDIV_ACC_EN
    ,
    OP_MADDU = OP_W'(14),
    OP_MSUBU = OP_W'(15)
`endif
  } hilo_op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CALC = 3'd1,
    S_FIX  = 3'd2,
    S_ACC  = 3'd3,
    S_WB   = 3'd4
  } hilo_state_e;

  typedef enum logic [2:0] {
    CORE_HOLD = 3'd0,
    CORE_LOAD = 3'd1,
    CORE_WR   = 3'd2,
    CORE_MUL  = 3'd3,
    CORE_DIV  = 3'd4
  } core_cmd_e;

  function automatic logic [XLEN_FIX-1:0] cond_neg32(input logic [XLEN_FIX-1:0] v,
                                                     input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [2*XLEN_FIX-1:0] cond_neg64(input logic [2*XLEN_FIX-1:0] v,
                                                       input logic neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

endpackage

// File: rtl/hilo_iter_core.sv
// Iteration datapath: 64-bit shift register plus the adder/subtractor for one
// radix-2 multiply step or one restoring-divide step, sequenced by the FSM.
module hilo_iter_core
  import hilo_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  core_cmd_e         cmd_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opnd_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] mul_step_s, div_step_s;
  logic [XLEN:0]     sum_s, rem_sh_s, diff_s;

  // Multiply: add multiplicand to upper half on LSB, shift right.
  // Divide: shift {rem,quot} left, trial-subtract divisor, restore on borrow.
  always_comb begin
    sum_s = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
    if (acc_q[0]) begin
      mul_step_s = {sum_s, acc_q[XLEN-1:1]};
    end else begin
      mul_step_s = {1'b0, acc_q[2*XLEN-1:1]};
    end
    rem_sh_s = acc_q[2*XLEN-1:XLEN-1];
    diff_s   = rem_sh_s - {1'b0, opnd_q};
    if (!diff_s[XLEN]) begin
      div_step_s = {diff_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      div_step_s = {rem_sh_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end
  end

  always_comb begin
    acc_d  = acc_q;
    opnd_d = opnd_q;
    case (cmd_i)
      CORE_LOAD: begin
        acc_d  = acc_i;
        opnd_d = opnd_i;
      end
      CORE_WR:   acc_d = acc_i;
      CORE_MUL:  acc_d = mul_step_s;
      CORE_DIV:  acc_d = div_step_s;
      default:   acc_d = acc_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q  <= '0;
      opnd_q <= '0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/hilo_muldiv_seq.sv
// HI/LO sequencer: MULT/MULTU/DIV/DIVU/MTHI/MTLO with a registered HI/LO write port.
// Optional HILO_MULDIV_ACC_EN adds MADD/MADDU/MSUB/MSUBU and hi_in_i/lo_in_i.
module hilo_muldiv_seq
  import hilo_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [OP_W-1:0] op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
`ifdef HILO_MULDIV_ACC_EN
  input  logic [XLEN-1:0] hi_in_i,
  input  logic [XLEN-1:0] lo_in_i,
`endif
  output logic            busy_o,
  output logic [XLEN-1:0] hi_out_o,
  output logic [XLEN-1:0] lo_out_o,
  output logic [1:0]      hl_write_o
);

  if (XLEN != 32) begin : g_xlen_chk
    $error("hilo_muldiv_seq: only XLEN=32 is supported");
  end

  hilo_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              is_div_q, is_div_d;
  logic              neg_q, neg_d;
  logic              rneg_q, rneg_d;
  logic [1:0]        mask_q, mask_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [1:0]        hlw_q, hlw_d;
`ifdef HILO_MULDIV_ACC_EN
  logic              macc_q, macc_d, sub_q, sub_d;
  logic [2*XLEN-1:0] hlacc_q, hlacc_d, acc_sum_s;
`endif

  core_cmd_e         core_cmd_s;
  logic [2*XLEN-1:0] core_in_s, core_acc_s, fix_s;
  logic [XLEN-1:0]   core_opnd_s;

  // Launch decode: what an accepted start would load
  logic              l_valid_s, l_busy_s, l_mul_s, l_dv_s, l_sgn_s;
  logic              l_neg_s, l_rneg_s, l_macc_s, l_sub_s;
  logic [1:0]        l_mask_s;
  hilo_state_e       l_state_s;
  logic [2*XLEN-1:0] l_acc_s;
  logic [XLEN-1:0]   l_opnd_s, abs_a_s, abs_b_s;
  logic              take_s, wb_s;

  // Classify the incoming op and prepare operand magnitudes
  always_comb begin
    l_mul_s  = 1'b0;
    l_dv_s   = 1'b0;
    l_sgn_s  = 1'b0;
    l_macc_s = 1'b0;
    l_sub_s  = 1'b0;
    l_mask_s = 2'b00;
    case (op_i)
      OP_MULT:  begin l_mul_s = 1'b1; l_sgn_s = 1'b1; end
      OP_MULTU: l_mul_s = 1'b1;
      OP_DIV:   begin l_dv_s = 1'b1; l_sgn_s = 1'b1; end
      OP_DIVU:  l_dv_s = 1'b1;
      OP_MTHI:  l_mask_s = 2'b10;
      OP_MTLO:  l_mask_s = 2'b01;
`ifdef HILO_MULDIV_ACC_EN
      OP_MADD:  begin l_mul_s = 1'b1; l_sgn_s = 1'b1; l_macc_s = 1'b1; end
      OP_MSUB:  begin l_mul_s = 1'b1; l_sgn_s = 1'b1; l_macc_s = 1'b1; l_sub_s = 1'b1; end
      OP_MADDU: begin l_mul_s = 1'b1; l_macc_s = 1'b1; end
      OP_MSUBU: begin l_mul_s = 1'b1; l_macc_s = 1'b1; l_sub_s = 1'b1; end
`endif
      default:  l_mul_s = 1'b0;
    endcase

    abs_a_s   = cond_neg32(a_i, l_sgn_s & a_i[XLEN-1]);
    abs_b_s   = cond_neg32(b_i, l_sgn_s & b_i[XLEN-1]);
    l_valid_s = 1'b1;
    l_state_s = S_CALC;
    l_busy_s  = 1'b1;
    l_acc_s   = {{XLEN{1'b0}}, abs_a_s};
    l_opnd_s  = abs_b_s;
    l_neg_s   = l_sgn_s & (a_i[XLEN-1] ^ b_i[XLEN-1]);
    l_rneg_s  = l_sgn_s & a_i[XLEN-1];
    if (l_mul_s) begin
      l_acc_s  = {{XLEN{1'b0}}, abs_b_s};
      l_opnd_s = abs_a_s;
      l_rneg_s = 1'b0;
      l_mask_s = 2'b11;
    end else if (l_dv_s && (b_i == '0)) begin
      // Divide by zero bypasses the iterations entirely
      l_state_s = S_WB;
      l_busy_s  = 1'b0;
      l_acc_s   = {a_i, {XLEN{1'b1}}};
      l_mask_s  = 2'b11;
    end else if (l_dv_s) begin
      l_mask_s = 2'b11;
    end else if (l_mask_s != 2'b00) begin
      l_state_s = S_WB;
      l_busy_s  = 1'b0;
      l_acc_s   = {a_i, a_i};
    end else begin
      l_valid_s = 1'b0;
      l_busy_s  = 1'b0;
      l_state_s = S_IDLE;
    end
  end

  // Sign fix-up of the raw magnitude result
  always_comb begin
    if (is_div_q) begin
      fix_s = {cond_neg32(core_acc_s[2*XLEN-1:XLEN], rneg_q),
               cond_neg32(core_acc_s[XLEN-1:0], neg_q)};
    end else begin
      fix_s = cond_neg64(core_acc_s, neg_q);
    end
  end

`ifdef HILO_MULDIV_ACC_EN
  assign acc_sum_s = sub_q ? (hlacc_q - core_acc_s) : (hlacc_q + core_acc_s);
`endif

  assign take_s = start_i && l_valid_s && !flush_i &&
                  ((state_q == S_IDLE) || (state_q == S_WB));

  // FSM next state and datapath control
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    busy_d      = 1'b0;
    is_div_d    = is_div_q;
    neg_d       = neg_q;
    rneg_d      = rneg_q;
    mask_d      = mask_q;
    core_cmd_s  = CORE_HOLD;
    core_in_s   = '0;
    core_opnd_s = '0;
`ifdef HILO_MULDIV_ACC_EN
    macc_d      = macc_q;
    sub_d       = sub_q;
    hlacc_d     = hlacc_q;
`endif
    if (flush_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (take_s) begin
      state_d     = l_state_s;
      cnt_d       = CNT_W'(ITER - 1);
      busy_d      = l_busy_s;
      is_div_d    = l_dv_s;
      neg_d       = l_neg_s;
      rneg_d      = l_rneg_s;
      mask_d      = l_mask_s;
      core_cmd_s  = CORE_LOAD;
      core_in_s   = l_acc_s;
      core_opnd_s = l_opnd_s;
`ifdef HILO_MULDIV_ACC_EN
      macc_d      = l_macc_s;
      sub_d       = l_sub_s;
      hlacc_d     = {hi_in_i, lo_in_i};
`endif
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_CALC: begin
          busy_d     = 1'b1;
          core_cmd_s = is_div_q ? CORE_DIV : CORE_MUL;
          if (cnt_q == '0) begin
            state_d = S_FIX;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_FIX: begin
          core_cmd_s = CORE_WR;
          core_in_s  = fix_s;
`ifdef HILO_MULDIV_ACC_EN
          if (macc_q) begin
            state_d = S_ACC;
            busy_d  = 1'b1;
          end else begin
            state_d = S_WB;
          end
`else
          state_d = S_WB;
`endif
        end
`ifdef HILO_MULDIV_ACC_EN
        S_ACC: begin
          core_cmd_s = CORE_WR;
          core_in_s  = acc_sum_s;
          state_d    = S_WB;
        end
`else
        S_ACC: state_d = S_IDLE;
`endif
        S_WB:    state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // The WB state transfers the result to the output registers
  always_comb begin
    wb_s  = (state_q == S_WB) && !flush_i;
    hi_d  = (wb_s && mask_q[1]) ? core_acc_s[2*XLEN-1:XLEN] : hi_q;
    lo_d  = (wb_s && mask_q[0]) ? core_acc_s[XLEN-1:0] : lo_q;
    hlw_d = wb_s ? mask_q : 2'b00;
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      mask_q   <= 2'b00;
      hi_q     <= '0;
      lo_q     <= '0;
      hlw_q    <= 2'b00;
`ifdef HILO_MULDIV_ACC_EN
      macc_q   <= 1'b0;
      sub_q    <= 1'b0;
      hlacc_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      mask_q   <= mask_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hlw_q    <= hlw_d;
`ifdef HILO_MULDIV_ACC_EN
      macc_q   <= macc_d;
      sub_q    <= sub_d;
      hlacc_q  <= hlacc_d;
`endif
    end
  end

  hilo_iter_core #(
    .XLEN (XLEN)
  ) u_core (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .cmd_i  (core_cmd_s),
    .acc_i  (core_in_s),
    .opnd_i (core_opnd_s),
    .acc_o  (core_acc_s)
  );

  // A flush arriving with the write pulse still cancels it
  assign hl_write_o = hlw_q & {~flush_i, ~flush_i};
  assign busy_o     = busy_q;
  assign hi_out_o   = hi_q;
  assign lo_out_o   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_seq.sv
// Directed self-checking bench for hilo_muldiv_seq with hand-computed results.
module tb_hilo_muldiv_seq;
  import hilo_pkg::*;

`ifdef HILO_MULDIV_ACC_EN
  localparam int LAT = 35;
`else
  localparam int LAT = 34;
`endif
  localparam int BUSY_CYC = LAT - 1;

  logic            clk, rst_n, start, flush;
  logic [OP_W-1:0] op;
  logic [31:0]     a, b;
  logic            busy;
  logic [31:0]     hi_out, lo_out;
  logic [1:0]      hl_write;
`ifdef HILO_MULDIV_ACC_EN
  logic [31:0]     hi_in, lo_in;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  hilo_muldiv_seq #(.XLEN(32)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .op_i       (op),
    .a_i        (a),
    .b_i        (b),
    .flush_i    (flush),
`ifdef HILO_MULDIV_ACC_EN
    .hi_in_i    (hi_in),
    .lo_in_i    (lo_in),
`endif
    .busy_o     (busy),
    .hi_out_o   (hi_out),
    .lo_out_o   (lo_out),
    .hl_write_o (hl_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command, wait (bounded) for the write pulse and check it
  task automatic run_op(input string tag, input logic [OP_W-1:0] op_v,
                        input logic [31:0] a_v, input logic [31:0] b_v,
                        input int exp_lat, input int exp_busy, input logic [1:0] exp_w,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cyc;
    int bcnt;
    start = 1'b1; op = op_v; a = a_v; b = b_v;
    tick();
    start = 1'b0;
    cyc = 0; bcnt = 0;
    while (hl_write == 2'b00 && cyc < 60) begin
      if (busy) bcnt++;
      tick();
      cyc++;
    end
    chk({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
    chk({tag, "_busy"}, 64'(bcnt), 64'(exp_busy));
    chk({tag, "_hlw"}, 64'(hl_write), 64'(exp_w));
    chk({tag, "_hi"}, 64'(hi_out), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(lo_out), 64'(exp_lo));
    tick();
    chk({tag, "_pulse"}, 64'(hl_write), 64'd0);
  endtask

  initial begin
    int cyc;
    logic seen_w, seen_b;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
`ifdef HILO_MULDIV_ACC_EN
    hi_in = '0; lo_in = '0;
`endif
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_hlw", 64'(hl_write), 64'd0);
    chk("rst_hi", 64'(hi_out), 64'd0);
    chk("rst_lo", 64'(lo_out), 64'd0);
    rst_n = 1'b1;
    tick();

    run_op("mult_neg", OP_MULT, 32'hFFFFFFFE, 32'd3, LAT, BUSY_CYC, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, LAT, BUSY_CYC, 2'b11, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_minsq", OP_MULT, 32'h80000000, 32'h80000000, LAT, BUSY_CYC, 2'b11, 32'h40000000, 32'h00000000);
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, LAT, BUSY_CYC, 2'b11, 32'd2, 32'd14);
    run_op("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, LAT, BUSY_CYC, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFFFFFE, LAT, BUSY_CYC, 2'b11, 32'd1, 32'hFFFFFFFD);
    run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, LAT, BUSY_CYC, 2'b11, 32'd0, 32'h80000000);
    run_op("divu_by0", OP_DIVU, 32'h00001234, 32'd0, 1, 0, 2'b11, 32'h00001234, 32'hFFFFFFFF);
    run_op("div_by0", OP_DIV, 32'h00005678, 32'd0, 1, 0, 2'b11, 32'h00005678, 32'hFFFFFFFF);
    run_op("mthi", OP_MTHI, 32'hDEADBEEF, 32'd0, 1, 0, 2'b10, 32'hDEADBEEF, 32'hFFFFFFFF);
    run_op("mtlo", OP_MTLO, 32'h0BADF00D, 32'd0, 1, 0, 2'b01, 32'hDEADBEEF, 32'h0BADF00D);

`ifndef HILO_MULDIV_ACC_EN
    // Undefined op code (MADD encoding without the accumulate feature)
    start = 1'b1; op = 3'd6; a = 32'd5; b = 32'd5;
    tick();
    start = 1'b0;
    seen_w = 1'b0; seen_b = 1'b0;
    for (int i = 0; i < 40; i++) begin
      seen_w |= (hl_write != 2'b00);
      seen_b |= busy;
      tick();
    end
    chk("undef_w", 64'(seen_w), 64'd0);
    chk("undef_busy", 64'(seen_b), 64'd0);
`endif

    // Second start while busy is ignored
    start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
    tick();
    start = 1'b0;
    repeat (4) tick();
    start = 1'b1; op = OP_MTHI; a = 32'h00000055;
    tick();
    start = 1'b0;
    cyc = 5;
    while (hl_write == 2'b00 && cyc < 60) begin
      tick();
      cyc++;
    end
    chk("ign_lat", 64'(cyc), 64'(LAT));
    chk("ign_hlw", 64'(hl_write), 64'(2'b11));
    chk("ign_hi", 64'(hi_out), 64'd2);
    chk("ign_lo", 64'(lo_out), 64'd14);
    tick();

    // Back-to-back: MTLO accepted in the WB state of a MULTU
    start = 1'b1; op = OP_MULTU; a = 32'd5; b = 32'd6;
    tick();
    start = 1'b0;
    repeat (LAT - 1) tick();
    start = 1'b1; op = OP_MTLO; a = 32'h00000077;
    tick();
    start = 1'b0;
    chk("b2b_hlw1", 64'(hl_write), 64'(2'b11));
    chk("b2b_lo1", 64'(lo_out), 64'd30);
    tick();
    chk("b2b_hlw2", 64'(hl_write), 64'(2'b01));
    chk("b2b_lo2", 64'(lo_out), 64'h77);
    chk("b2b_hi2", 64'(hi_out), 64'd0);
    tick();

    // Flush in CALC
    start = 1'b1; op = OP_MULTU; a = 32'd3; b = 32'd3;
    tick();
    start = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    seen_w = 1'b0;
    for (int i = 0; i < 40; i++) begin
      seen_w |= (hl_write != 2'b00);
      tick();
    end
    chk("flush_now", 64'(seen_w), 64'd0);
    chk("flush_lo", 64'(lo_out), 64'h77);

    // Flush in the WB state drops the write
    start = 1'b1; op = OP_MTHI; a = 32'h00000099;
    tick();
    start = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flushwb_hlw", 64'(hl_write), 64'd0);
    chk("flushwb_hi", 64'(hi_out), 64'd0);
    tick();

    // Flush during the write pulse gates it combinationally
    start = 1'b1; op = OP_MTHI; a = 32'h000000AA;
    tick();
    start = 1'b0;
    tick();
    flush = 1'b1;
    #1;
    chk("flushcomb_hlw", 64'(hl_write), 64'd0);
    flush = 1'b0;
    #1;
    chk("flushcomb_rel", 64'(hl_write), 64'(2'b10));
    chk("flushcomb_hi", 64'(hi_out), 64'hAA);
    tick();

    // Asynchronous reset mid-operation
    start = 1'b1; op = OP_MULT; a = 32'd7; b = 32'd7;
    tick();
    start = 1'b0;
    repeat (19) tick();
    chk("pre_rst_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_hlw", 64'(hl_write), 64'd0);
    chk("arst_hi", 64'(hi_out), 64'd0);
    chk("arst_lo", 64'(lo_out), 64'd0);
    tick();
    rst_n = 1'b1;
    repeat (40) tick();
    chk("arst_idle", 64'(hl_write), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
